// File: rtl/factorial_seq.sv
// factorial_seq: iterative n! engine, one multiply per cycle, valid/ready on both sides.
// Define FACT_OVF_SAT_EN to saturate the result to all-ones once overflow is detected.
`timescale 1ns / 1ps
module factorial_seq #(
   parameter int unsigned N_W   = 4,
   parameter int unsigned OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_W-1:0]   in_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_fact,
   output logic             out_ovf,
   output logic             busy
);

   localparam int unsigned PW = OUT_W + N_W;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [N_W-1:0]   cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [OUT_W-1:0] fact_q, fact_d;
   logic             oovf_q, oovf_d;
   logic             ovalid_q, ovalid_d;
   logic [PW-1:0]    prod;
   logic             prod_ovf;

   assign prod     = PW'(acc_q) * PW'(cnt_q);
   assign prod_ovf = |prod[PW-1:OUT_W];

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      fact_d   = fact_q;
      oovf_d   = oovf_q;
      ovalid_d = ovalid_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               acc_d   = OUT_W'(1);
               cnt_d   = in_num;
               ovf_d   = 1'b0;
               state_d = (in_num >= N_W'(2)) ? StMul : StDone;
            end
         end
         StMul: begin
            ovf_d = ovf_q | prod_ovf;
            acc_d = prod[OUT_W-1:0];
`ifdef FACT_OVF_SAT_EN
            if (ovf_d) begin
               acc_d = '1;
            end
`endif
            cnt_d = cnt_q - N_W'(1);
            if (cnt_q == N_W'(2)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // First DONE cycle registers the result; it is then held until consumed.
            if (!ovalid_q) begin
               ovalid_d = 1'b1;
               fact_d   = acc_q;
               oovf_d   = ovf_q;
            end else if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         fact_q   <= '0;
         oovf_q   <= 1'b0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         fact_q   <= fact_d;
         oovf_q   <= oovf_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = ovalid_q;
   assign out_fact  = fact_q;
   assign out_ovf   = oovf_q;

endmodule

// File: tb/tb_factorial_seq.sv
// Self-checking bench for factorial_seq against an arithmetic reference model.
`timescale 1ns / 1ps
module tb_factorial_seq;

   localparam int unsigned N_W   = 4;
   localparam int unsigned OUT_W = 32;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   logic [N_W-1:0]   in_num    = '0;
   logic             in_ready, out_valid, out_ovf, busy;
   logic [OUT_W-1:0] out_fact;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int               acc_cyc[$];
   int               hs_cyc[$];
   logic [OUT_W-1:0] hs_fact[$];

   factorial_seq #(.N_W(N_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fact  (out_fact),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Handshake log: which cycle each accept / result transfer happened on.
   always @(posedge clk) begin
      cyc++;
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
         hs_cyc.push_back(cyc);
         hs_fact.push_back(out_fact);
      end
   end

   function automatic logic [63:0] full_fact(int n);
      logic [63:0] f;
      f = 64'd1;
      for (int i = 2; i <= n; i++) f = f * 64'(i);
      return f;
   endfunction

   function automatic logic ref_ovf(int n);
      return (full_fact(n) >> OUT_W) != 64'd0;
   endfunction

   function automatic logic [OUT_W-1:0] ref_fact(int n);
      logic [63:0] f;
      f = full_fact(n);
`ifdef FACT_OVF_SAT_EN
      if (ref_ovf(n)) return '1;
`endif
      return f[OUT_W-1:0];
   endfunction

   function automatic int ref_lat(int n);
      return (n <= 1) ? 1 : n;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(int n);
      int k;
      k        = 0;
      in_valid = 1'b1;
      in_num   = N_W'(n);
      while (!in_ready && k < 50) begin
         step();
         k++;
      end
      chk("accept_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_num   = N_W'($urandom);
      chk("busy_after_accept", 64'(busy), 64'd1);
   endtask

   task automatic wait_result(int n);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!out_valid && k < 40);
      chk($sformatf("latency_n%0d", n), 64'(k), 64'(ref_lat(n)));
      chk($sformatf("fact_n%0d", n), 64'(out_fact), 64'(ref_fact(n)));
      chk($sformatf("ovf_n%0d", n), 64'(out_ovf), 64'(ref_ovf(n)));
   endtask

   task automatic drain(int n, int stall);
      for (int i = 0; i < stall; i++) begin
         step();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_fact", 64'(out_fact), 64'(ref_fact(n)));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_hs_valid", 64'(out_valid), 64'd0);
      chk("post_hs_ready", 64'(in_ready), 64'd1);
      chk("hold_fact", 64'(out_fact), 64'(ref_fact(n)));
   endtask

   initial begin
      int dir_n[7] = '{0, 1, 5, 12, 13, 14, 15};
      int k;
      int n;

      // Reset values
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_fact", 64'(out_fact), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      step();

      // Directed operands, including the overflow boundary
      foreach (dir_n[i]) begin
         accept(dir_n[i]);
         wait_result(dir_n[i]);
         drain(dir_n[i], 0);
      end

      // Back-pressure: result held, new request ignored until the handshake
      accept(6);
      wait_result(6);
      in_valid = 1'b1;
      in_num   = N_W'(3);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_fact", 64'(out_fact), 64'd720);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      acc_cyc.delete();
      hs_cyc.delete();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("bp_accepts", 64'(acc_cyc.size()), 64'd1);
      chk("bp_hs", 64'(hs_cyc.size()), 64'd1);
      if (acc_cyc.size() == 1 && hs_cyc.size() == 1)
         chk("bp_accept_cycle", 64'(acc_cyc[0]), 64'(hs_cyc[0] + 1));
      wait_result(3);
      drain(3, 0);

      // Asynchronous reset in the middle of a multiply sequence
      accept(9);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_out_fact", 64'(out_fact), 64'd0);
      chk("mid_rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      #2 rst_n = 1'b1;
      step();
      accept(4);
      wait_result(4);
      drain(4, 0);

      // Back-to-back with in_valid held and no back-pressure
      acc_cyc.delete();
      hs_cyc.delete();
      hs_fact.delete();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         k      = 0;
         in_num = N_W'(i + 2);
         while (!in_ready && k < 50) begin
            step();
            k++;
         end
         step();
      end
      in_valid = 1'b0;
      k        = 0;
      while (hs_cyc.size() < 3 && k < 50) begin
         step();
         k++;
      end
      out_ready = 1'b0;
      chk("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
      chk("b2b_results", 64'(hs_cyc.size()), 64'd3);
      if (acc_cyc.size() == 3 && hs_cyc.size() == 3) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_fact%0d", i), 64'(hs_fact[i]), 64'(ref_fact(i + 2)));
         for (int i = 0; i < 2; i++)
            chk($sformatf("b2b_gap%0d", i), 64'(acc_cyc[i+1]), 64'(hs_cyc[i] + 1));
      end

      // Randomized operands and consumer stalls
      for (int r = 0; r < 12; r++) begin
         n = int'($urandom_range(0, 15));
         accept(n);
         wait_result(n);
         drain(n, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/factorial_seq.md
# factorial_seq

Iterative, clocked factorial engine. It accepts a small unsigned operand over a valid/ready handshake and computes n! with one multiply per cycle. It presents the result and an overflow flag over a second valid/ready handshake. It is the registered compute stage that sits between the operand source and result consumers in the factorial path, and it replaces zero-time combinational evaluation with a cycle-accurate, back-pressurable unit.

## Interface
- `N_W`, default 4: operand width; n ranges 0..2^N_W-1.
- `OUT_W`, default 32: result width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand present.
- `in_ready` out 1: engine can accept; high only in IDLE.
- `in_num` in N_W: operand n, sampled on the accept edge.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result.
- `out_fact` out OUT_W: n!, truncated or saturated (see Configuration).
- `out_ovf` out 1: true n! does not fit in OUT_W bits.
- `busy` out 1: state is not IDLE.

## Operation
- Reset values:
  - State is IDLE.
  - `in_ready`=1, `out_valid`=0, `out_fact`=0, `out_ovf`=0, `busy`=0.
  - Internal accumulator and counter are 0.
- States are IDLE, MUL and DONE.
- IDLE:
  - An accept occurs on the edge where `in_valid && in_ready`.
  - On accept: acc<=1, cnt<=in_num, ovf<=0.
  - Next state is MUL if in_num>=2, else DONE.
- MUL:
  - Each cycle, full product p = acc*cnt (OUT_W+N_W bits) is formed.
  - acc<=p[OUT_W-1:0], cnt<=cnt-1.
  - ovf<=ovf | (p[OUT_W+N_W-1:OUT_W]!=0).
  - Multiplication order is descending: n, n-1, …, 2.
  - When cnt==2 the step is taken and the next state is DONE.
- DONE:
  - `out_valid`=1; `out_fact`=acc; `out_ovf`=ovf.
  - On the edge where `out_valid && out_ready`, the next state is IDLE.
  - Outputs are held stable while `out_ready`=0.
- `in_num` changes after accept are ignored.
- `in_valid` while busy is not accepted; the upstream stage holds it.
- 0! = 1! = 1, with no MUL cycles.
- `out_fact` is valid only while `out_valid`=1. Otherwise it holds its last value.
- Reset mid-operation: the async clear returns the engine to the reset values immediately. The in-flight result is discarded.

## Timing
- Accept on edge T0:
  - n<=1: `out_valid` high after edge T0+1.
  - n>=2: `out_valid` high after edge T0+(n-1)+1 = T0+n.
- Result handshake on edge Tr: `in_ready` high after Tr. The earliest next accept is edge Tr+1.
- Throughput is one result per n+2 cycles (n>=2) with zero back-pressure.
- `in_ready` and `busy` are registered-state decodes, so there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `FACT_OVF_SAT_EN`:
  - Defined: once ovf is set, acc is forced to all-ones and stays all-ones for the rest of the operation. `out_fact` = 2^OUT_W-1 on overflow.
  - Undefined: `out_fact` = true n! mod 2^OUT_W (plain truncation).
  - `out_ovf` behaves identically in both builds.

## Test plan
- Reset, then n=0 and n=1 with `out_ready`=1 -> `out_fact`=1, `out_ovf`=0, `out_valid` one cycle after accept.
- n=5 -> `out_fact`=120, `out_valid` exactly 5 cycles after accept. n=12 -> 479001600, `out_ovf`=0, latency 12.
- n=13, 14, 15 with macro undefined -> `out_fact`=1932053504, 1278945280, 2004310016 respectively, `out_ovf`=1. With `FACT_OVF_SAT_EN` defined -> `out_fact`=32'hFFFFFFFF, `out_ovf`=1.
- n=6 with `out_ready` held 0 for 10 cycles -> `out_fact`=720 stable and `out_valid` held. `in_ready`=0 and a new `in_valid`/`in_num`=3 is ignored. After `out_ready`=1, n=3 is accepted the following cycle -> 6.
- `rst_n` pulsed low during MUL of n=9 (cycle 4) -> all outputs return to reset values asynchronously. The next operation n=4 -> 24 with normal latency.
- Back-to-back n=2,3,4 with `in_valid` held and `out_ready`=1 -> results 2, 6, 24 in order. Each accept occurs one cycle after the prior result handshake.
